// File: rtl/seg_scan_mux.sv
// Time-multiplexed N-digit 7-segment controller: hex decode, LZ blanking, blink, DP, frame-coherent snapshot.
// All outputs registered (1-cycle latency from scan state); no backpressure, free-running scan.
module seg_scan_mux #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int SW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIGITS-1:0] ONE = DIGITS'(1);

  logic [SW-1:0]         slot_cnt;
  logic [IW-1:0]         idx;
  logic [BW-1:0]         blink_cnt;
  logic                  blink_phase;
  logic [4*DIGITS-1:0]   dig_s;
  logic [DIGITS-1:0]     dp_s;
  logic [DIGITS-1:0]     blink_s;
  logic                  lz_s;

  logic                  slot_end;
  logic                  frame_end;
  logic                  show;
  logic [3:0]            cur_dig;
  logic [DIGITS-1:0]     lz_sup;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'h40;
      4'h1:    hex7 = 7'h79;
      4'h2:    hex7 = 7'h24;
      4'h3:    hex7 = 7'h30;
      4'h4:    hex7 = 7'h19;
      4'h5:    hex7 = 7'h12;
      4'h6:    hex7 = 7'h02;
      4'h7:    hex7 = 7'h78;
      4'h8:    hex7 = 7'h00;
      4'h9:    hex7 = 7'h10;
      4'hA:    hex7 = 7'h08;
      4'hB:    hex7 = 7'h03;
      4'hC:    hex7 = 7'h46;
      4'hD:    hex7 = 7'h21;
      4'hE:    hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign slot_end  = (slot_cnt == SW'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (idx == IW'(DIGITS - 1));
  assign cur_dig   = dig_s[4*idx +: 4];

  // A digit is a leading zero when it and everything above it is zero with no DP lit.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lz_sup     = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (dig_s[4*i +: 4] == 4'h0) && !dp_s[i];
      lz_sup[i]  = lz_s && (i != 0) && upper_zero;
    end
  end

  assign show = en && (slot_cnt >= SW'(BLANK_CYC))
                   && !(blink_s[idx] && blink_phase)
                   && !lz_sup[idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt    <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      dig_s       <= '0;
      dp_s        <= '0;
      blink_s     <= '0;
      lz_s        <= 1'b0;
      an          <= '1;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      frame_tick  <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      slot_cnt   <= slot_end ? '0 : slot_cnt + 1'b1;
      if (slot_end)
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      // Snapshot only at frame boundaries so a frame never mixes old and new values.
      if (frame_end) begin
        dig_s   <= digits_in;
        dp_s    <= dp_mask;
        blink_s <= blink_mask;
        lz_s    <= lz_blank;
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
      an  <= show ? ~(ONE << idx) : '1;
      seg <= show ? hex7(cur_dig) : 7'h7F;
      dp  <= show ? ~dp_s[idx] : 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: directed phases plus random inputs against a position-based reference model.
module tb_seg_scan_mux;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int BL = 2;
  localparam int BF = 2;
  localparam int FRAME = D * RD;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           en = 1'b1;
  logic [4*D-1:0] digits_in = '0;
  logic [D-1:0]   dp_mask = '0;
  logic [D-1:0]   blink_mask = '0;
  logic           lz_blank = 1'b0;
  logic [6:0]     seg;
  logic           dp;
  logic [D-1:0]   an;
  logic           frame_tick;

  int checks = 0;
  int errors = 0;

  // reference model state: edges since reset release plus the frame snapshot
  int             p = 0;
  logic [4*D-1:0] snap_dig = '0;
  logic [D-1:0]   snap_dp = '0;
  logic [D-1:0]   snap_blink = '0;
  logic           snap_lz = 1'b0;

  logic [6:0] dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_mux #(.DIGITS(D), .REFRESH_DIV(RD), .BLANK_CYC(BL), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .en(en), .digits_in(digits_in), .dp_mask(dp_mask),
    .blink_mask(blink_mask), .lz_blank(lz_blank), .seg(seg), .dp(dp), .an(an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h (p=%0d)", tag, got, exp, p);
    end
  endtask

  function automatic bit lz_supp(input int i);
    int hi;
    hi = 0;
    for (int j = 0; j < D; j++)
      if (snap_dig[4*j +: 4] != 4'h0 || snap_dp[j]) hi = j;
    return snap_lz && (i > hi);
  endfunction

  // One clock: derive expected outputs from the pre-edge scan position, then compare after the edge.
  task automatic step();
    int slot, id, f;
    bit show;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_ft;
    slot = p % RD;
    id   = (p / RD) % D;
    f    = p / FRAME;
    show = en && (slot >= BL) && !(snap_blink[id] && ((f / BF) % 2 == 1)) && !lz_supp(id);
    e_an  = show ? ~(4'b0001 << id) : 4'hF;
    e_seg = show ? dec_tbl[snap_dig[4*id +: 4]] : 7'h7F;
    e_dp  = show ? ~snap_dp[id] : 1'b1;
    e_ft  = (p % FRAME == FRAME - 1);
    if (e_ft) begin
      snap_dig   = digits_in;
      snap_dp    = dp_mask;
      snap_blink = blink_mask;
      snap_lz    = lz_blank;
    end
    p++;
    @(posedge clk);
    #1;
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("frame_tick", 32'(frame_tick), 32'(e_ft));
  endtask

  task automatic model_reset();
    p          = 0;
    snap_dig   = '0;
    snap_dp    = '0;
    snap_blink = '0;
    snap_lz    = 1'b0;
  endtask

  initial begin
    int first_lit;
    // reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_ft", 32'(frame_tick), 32'h0);
    reset = 1'b1;
    model_reset();

    // plain scan of 1234 (first frame shows the zero snapshot)
    digits_in = 16'h1234;
    for (int k = 0; k < 3 * FRAME; k++) step();

    // leading-zero blanking, then a DP keeps digit 2 alive
    digits_in = 16'h0070;
    lz_blank  = 1'b1;
    for (int k = 0; k < 2 * FRAME; k++) step();
    dp_mask = 4'b0100;
    for (int k = 0; k < 2 * FRAME; k++) step();

    // blink on digit 0 across several blink half-periods
    dp_mask    = 4'b0000;
    lz_blank   = 1'b0;
    digits_in  = 16'h5678;
    blink_mask = 4'b0001;
    for (int k = 0; k < 8 * FRAME; k++) step();
    blink_mask = 4'b0000;

    // mid-frame input change must not tear the frame
    digits_in = 16'h1111;
    for (int k = 0; k < 2 * FRAME + 13; k++) step();
    digits_in = 16'h2222;
    for (int k = 0; k < 2 * FRAME; k++) step();

    // display off for 40 cycles, scan keeps running
    en = 1'b0;
    for (int k = 0; k < 40; k++) step();
    en = 1'b1;
    for (int k = 0; k < FRAME; k++) step();

    // random inputs
    for (int k = 0; k < 640; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        digits_in  = 16'($urandom);
        dp_mask    = 4'($urandom);
        blink_mask = 4'($urandom);
        lz_blank   = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 31) == 0) en = ($urandom_range(0, 3) != 0);
      step();
    end

    // asynchronous reset while a digit is lit
    en = 1'b1; dp_mask = '0; blink_mask = '0; lz_blank = 1'b0; digits_in = 16'h8888;
    for (int k = 0; k < 2 * FRAME; k++) step();
    while (p % RD != BL + 3) step();
    chk("pre_rst_lit", 32'(an == 4'hF), 32'h0);
    reset = 1'b0;
    #1;
    chk("async_an", 32'(an), 32'hF);
    chk("async_seg", 32'(seg), 32'h7F);
    chk("async_dp", 32'(dp), 32'h1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    first_lit = -1;
    for (int k = 1; k <= 2 * FRAME; k++) begin
      step();
      if (first_lit < 0 && an[0] == 1'b0) first_lit = k;
    end
    chk("first_lit_cycle", 32'(first_lit), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
